// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction and data requesters, one transaction in flight.
// Build option ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests (default: data wins).
module mem_port_arbiter #(
   parameter int NBITS          = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_proc_req,
   output logic             i_mem_rdy,
   input  logic [NBITS-1:0] i_addr,
   output logic [NBITS-1:0] i_rdata,
   output logic             i_valid,
   input  logic             d_proc_req,
   output logic             d_mem_rdy,
   input  logic [NBITS-1:0] d_addr,
   input  logic             d_we,
   input  logic [NBITS-1:0] d_wdata,
   output logic [NBITS-1:0] d_rdata,
   output logic             d_valid,
   output logic             m_proc_req,
   input  logic             m_mem_rdy,
   output logic [NBITS-1:0] m_addr,
   output logic             m_we,
   output logic [NBITS-1:0] m_wdata,
   input  logic [NBITS-1:0] m_rdata,
   input  logic             m_valid,
   output logic             timeout_err
);
   // state  | meaning
   // IDLE   | port free, winner of this cycle's requests drives the memory port
   // WAIT_I | instruction request accepted, waiting for m_valid or watchdog
   // WAIT_D | data request accepted, waiting for m_valid or watchdog

   localparam int             CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CW-1:0]  CNT_MAX  = '1;
   localparam bit             WD_EN    = (TIMEOUT_CYCLES > 0);

   typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          last_grant_d;
   logic          grant_i;
   logic          grant_d;
   logic          accept;
   logic          wd_fire;

   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state == IDLE && !rst) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (i_proc_req && d_proc_req) begin
            grant_d = !last_grant_d;
            grant_i = last_grant_d;
         end else begin
            grant_d = d_proc_req;
            grant_i = i_proc_req;
         end
`else
         grant_d = d_proc_req;
         grant_i = i_proc_req && !d_proc_req;
`endif
      end
   end

   assign accept     = (grant_i || grant_d) && m_mem_rdy;
   assign m_proc_req = grant_i || grant_d;
   assign m_addr     = grant_d ? d_addr : (grant_i ? i_addr : '0);
   assign m_we       = grant_d && d_we;
   assign m_wdata    = grant_d ? d_wdata : '0;
   assign i_mem_rdy  = grant_i && m_mem_rdy;
   assign d_mem_rdy  = grant_d && m_mem_rdy;

   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;
   assign i_valid = !rst && (state == WAIT_I) && m_valid;
   assign d_valid = !rst && (state == WAIT_D) && m_valid;

   // A response arriving on the last allowed cycle beats the watchdog.
   assign wd_fire     = WD_EN && !rst && (state != IDLE) && !m_valid && (cnt == CNT_LAST);
   assign timeout_err = wd_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         last_grant_d <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (accept) begin
                  state        <= grant_d ? WAIT_D : WAIT_I;
                  last_grant_d <= grant_d;
               end
            end
            WAIT_I, WAIT_D: begin
               if (m_valid || wd_fire) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants/responses, a negedge
// monitor pops and compares them whenever the DUT shows an accept, a valid or a timeout.
module tb_mem_port_arbiter;
   localparam int NBITS = 32;
   localparam int TMO   = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_proc_req = 1'b0, d_proc_req = 1'b0, d_we = 1'b0;
   logic [NBITS-1:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
   logic             m_mem_rdy = 1'b0, m_valid = 1'b0;
   logic             i_mem_rdy, i_valid, d_mem_rdy, d_valid, m_proc_req, m_we, timeout_err;
   logic [NBITS-1:0] i_rdata, d_rdata, m_addr, m_wdata;

   mem_port_arbiter #(.NBITS(NBITS), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .i_proc_req(i_proc_req), .i_mem_rdy(i_mem_rdy), .i_addr(i_addr), .i_rdata(i_rdata),
      .i_valid(i_valid),
      .d_proc_req(d_proc_req), .d_mem_rdy(d_mem_rdy), .d_addr(d_addr), .d_we(d_we),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
      .m_proc_req(m_proc_req), .m_mem_rdy(m_mem_rdy), .m_addr(m_addr), .m_we(m_we),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_valid(m_valid), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct { bit side_d; logic [NBITS-1:0] addr; bit we; logic [NBITS-1:0] wdata; } grant_t;
   typedef struct { bit side_d; bit tmo; logic [NBITS-1:0] rdata; } resp_t;

   grant_t gq[$];
   resp_t  rq[$];
   int     checks = 0;
   int     errors = 0;

   // reference model: port busy flag, owner, cycles waited, planned response latency
   bit               busy = 0, owner_d = 0, last_d = 0;
   int               wait_cnt = 0, lat = 0, force_lat = 0;
   bit               use_rdata = 0, stray_valid = 0;
   logic [NBITS-1:0] force_rdata = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic bit pick_d(input bit i_req, input bit d_req, input bit last_was_d);
`ifdef ARB_ROUND_ROBIN_EN
      if (i_req && d_req) return !last_was_d;
`endif
      return d_req;
   endfunction

   // one clock of stimulus; inputs already set by the caller
   task automatic step();
      grant_t g;
      resp_t  r;
      if (busy) begin
         wait_cnt++;
         m_rdata = use_rdata ? force_rdata : NBITS'($urandom);
         m_valid = (wait_cnt == lat);
         if (m_valid) begin
            r = '{side_d: owner_d, tmo: 1'b0, rdata: m_rdata};
            rq.push_back(r);
            busy = 0;
         end else if (wait_cnt == TMO) begin
            r = '{side_d: owner_d, tmo: 1'b1, rdata: '0};
            rq.push_back(r);
            busy = 0;
         end
      end else begin
         m_valid = stray_valid;
         m_rdata = NBITS'($urandom);
         if ((i_proc_req || d_proc_req) && m_mem_rdy) begin
            owner_d = pick_d(i_proc_req, d_proc_req, last_d);
            g = '{side_d: owner_d, addr: owner_d ? d_addr : i_addr,
                  we: owner_d && d_we, wdata: owner_d ? d_wdata : '0};
            gq.push_back(g);
            last_d   = owner_d;
            busy     = 1;
            wait_cnt = 0;
            lat      = (force_lat != 0) ? force_lat : int'($urandom_range(1, 10));
            force_lat = 0;
         end
      end
      @(posedge clk);
      #1;
      m_valid = 1'b0;
   endtask

   task automatic drain();
      i_proc_req  = 0;
      d_proc_req  = 0;
      stray_valid = 0;
      for (int k = 0; k < 3 * TMO && busy; k++) step();
   endtask

   always @(negedge clk) begin
      grant_t g;
      resp_t  r;
      if (!rst) begin
         if (m_proc_req && m_mem_rdy) begin
            chk("grant_expected", gq.size() > 0, 1);
            if (gq.size() > 0) begin
               g = gq.pop_front();
               chk("grant_side", {d_mem_rdy, i_mem_rdy}, g.side_d ? 2'b10 : 2'b01);
               chk("grant_addr", m_addr, g.addr);
               chk("grant_we", m_we, g.we);
               chk("grant_wdata", m_wdata, g.wdata);
            end
         end
         if (i_valid || d_valid || timeout_err) begin
            chk("resp_expected", rq.size() > 0, 1);
            if (rq.size() > 0) begin
               r = rq.pop_front();
               chk("resp_flags", {timeout_err, d_valid, i_valid},
                   r.tmo ? 3'b100 : (r.side_d ? 3'b010 : 3'b001));
               if (!r.tmo) chk("resp_rdata", r.side_d ? d_rdata : i_rdata, r.rdata);
            end
         end
      end
   end

   initial begin
      bit exp_d;
      // reset: everything quiet even with requests and a ready memory
      i_proc_req = 1; d_proc_req = 1; m_mem_rdy = 1; m_valid = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_proc_req", m_proc_req, 0);
      chk("rst_rdy", {i_mem_rdy, d_mem_rdy}, 2'b00);
      chk("rst_valid", {i_valid, d_valid}, 2'b00);
      chk("rst_timeout_err", timeout_err, 0);
      rst = 0; m_valid = 0; i_proc_req = 0; d_proc_req = 0;
      @(posedge clk);
      #1;

      // instruction read, response two cycles after accept
      i_proc_req = 1; i_addr = 32'h100; m_mem_rdy = 1;
      force_lat = 2; use_rdata = 1; force_rdata = 32'h0050_0093;
      step();
      i_proc_req = 0;
      step(); step();
      use_rdata = 0;
      drain();

      // both requesting: first grant follows the arbitration rule, then keep both busy
      i_proc_req = 1; i_addr = 32'h300;
      d_proc_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; m_mem_rdy = 1;
      #1;
      exp_d = pick_d(1, 1, last_d);
      chk("both_m_addr", m_addr, exp_d ? 32'h2000 : 32'h300);
      chk("both_m_we", m_we, exp_d);
      for (int t = 0; t < 4; t++) begin
         force_lat = 1;
         step();
         step();
      end
      drain();

      // watchdog: no response ever, then a fresh request must still be accepted
      d_proc_req = 1; d_we = 0; d_addr = 32'h44; m_mem_rdy = 1; force_lat = 99;
      step();
      d_proc_req = 0;
      for (int k = 0; k < TMO; k++) step();
      i_proc_req = 1; i_addr = 32'h80; force_lat = 1;
      step();
      drain();

      // reset while WAIT_D, stray response after reset is dropped
      d_proc_req = 1; m_mem_rdy = 1; force_lat = 99;
      step();
      d_proc_req = 0; rst = 1; m_valid = 0;
      @(posedge clk);
      #1;
      rst = 0; busy = 0; last_d = 0;
      step();
      stray_valid = 1;
      #1;
      m_valid = 1;
      #1;
      chk("post_rst_d_valid", d_valid, 0);
      step();
      stray_valid = 0;
      i_proc_req = 1; i_addr = 32'h10; force_lat = 1;
      step();
      drain();

      // memory stalls: data request held without ready
      d_proc_req = 1; d_addr = 32'h600; m_mem_rdy = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("stall_d_mem_rdy", d_mem_rdy, 0);
         chk("stall_m_proc_req", m_proc_req, 1);
         step();
      end
      m_mem_rdy = 1;
      #1;
      chk("unstall_d_mem_rdy", d_mem_rdy, 1);
      step();
      drain();

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         i_proc_req  = ($urandom_range(0, 99) < 40);
         d_proc_req  = ($urandom_range(0, 99) < 40);
         i_addr      = NBITS'($urandom);
         d_addr      = NBITS'($urandom);
         d_we        = 1'($urandom);
         d_wdata     = NBITS'($urandom);
         m_mem_rdy   = ($urandom_range(0, 99) < 70);
         stray_valid = ($urandom_range(0, 9) == 0);
         step();
      end
      drain();
      repeat (3) step();

      chk("grant_queue_empty", gq.size(), 0);
      chk("resp_queue_empty", rq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
